// File: rtl/ssram_fwft_ctrl_if.sv
// Producer/consumer handshake and SSRAM port bundle for the FWFT FIFO controller.
// slave = controller side, master = producer/consumer plus the SSRAM instance.
interface ssram_fwft_ctrl_if #(
   parameter int Depth = 512,
   parameter int Width = 8
);
   localparam int AW = $clog2(Depth);
   localparam int CW = AW + 1;

   logic             push;
   logic [Width-1:0] push_data;
   logic             pop;
   logic [Width-1:0] pop_data;
   logic             pop_valid;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             underflow;
   logic             clr_err;
   logic             mem_wr_en;
   logic [AW-1:0]    mem_wr_addr;
   logic [Width-1:0] mem_wr_data;
   logic             mem_rd_en;
   logic [AW-1:0]    mem_rd_addr;
   logic [Width-1:0] mem_rd_data;

   modport slave (
      input  push, push_data, pop, clr_err, mem_rd_data,
      output pop_data, pop_valid, full, empty, almost_full, almost_empty, count,
             overflow, underflow, mem_wr_en, mem_wr_addr, mem_wr_data,
             mem_rd_en, mem_rd_addr
   );

   modport master (
      output push, push_data, pop, clr_err, mem_rd_data,
      input  pop_data, pop_valid, full, empty, almost_full, almost_empty, count,
             overflow, underflow, mem_wr_en, mem_wr_addr, mem_wr_data,
             mem_rd_en, mem_rd_addr
   );
endinterface

// File: rtl/ssram_fwft_ctrl.sv
// FWFT FIFO controller for one registered-read SSRAM; the SSRAM read register is
// the output stage, so prefetch keeps it loaded whenever words are waiting.
module ssram_fwft_ctrl #(
   parameter int Depth       = 512,
   parameter int Width       = 8,
   parameter int AlmostFull  = Depth - 4,
   parameter int AlmostEmpty = 4
) (
   input logic               clk,
   input logic               rst_n,
   ssram_fwft_ctrl_if.slave  bus
);
   localparam int AW = $clog2(Depth);
   localparam int CW = AW + 1;

   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic [CW-1:0]    r_ram_cnt;
   logic             r_pop_valid;
   logic             r_overflow;
   logic             r_underflow;

   logic             w_full;
   logic             w_wr_acc;
   logic             w_pop_acc;
   logic             w_fetch;
   logic             w_ovf_evt;
   logic             w_unf_evt;
   logic [Width-1:0] w_head;

   assign w_full    = (r_count == CW'(Depth));
   assign w_wr_acc  = bus.push & ~w_full;
   assign w_pop_acc = bus.pop & r_pop_valid;
   // Registered ram_cnt only: a word written this cycle cannot be fetched until next cycle.
   assign w_fetch   = (r_ram_cnt != '0) & (~r_pop_valid | w_pop_acc);
   assign w_ovf_evt = bus.push & w_full;
   assign w_unf_evt = bus.pop & ~r_pop_valid;
   assign w_head    = bus.mem_rd_data;

   assign bus.mem_wr_en    = w_wr_acc;
   assign bus.mem_wr_addr  = r_wptr;
   assign bus.mem_wr_data  = bus.push_data;
   assign bus.mem_rd_en    = w_fetch;
   assign bus.mem_rd_addr  = r_rptr;

   assign bus.pop_data     = w_head;
   assign bus.pop_valid    = r_pop_valid;
   assign bus.count        = r_count;
   assign bus.full         = w_full;
   assign bus.empty        = (r_count == '0);
   assign bus.almost_full  = (r_count >= CW'(AlmostFull));
   assign bus.almost_empty = (r_count <= CW'(AlmostEmpty));
   assign bus.overflow     = r_overflow;
   assign bus.underflow    = r_underflow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_ram_cnt   <= '0;
         r_pop_valid <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
         if (w_fetch)  r_rptr <= r_rptr + AW'(1);
         r_pop_valid <= w_fetch | (r_pop_valid & ~w_pop_acc);
         r_ram_cnt   <= r_ram_cnt + CW'(w_wr_acc) - CW'(w_fetch);
         r_count     <= r_count + CW'(w_wr_acc) - CW'(w_pop_acc);
         // A new error in the same cycle as clr_err keeps the flag set.
         if (w_ovf_evt)        r_overflow  <= 1'b1;
         else if (bus.clr_err) r_overflow  <= 1'b0;
         if (w_unf_evt)        r_underflow <= 1'b1;
         else if (bus.clr_err) r_underflow <= 1'b0;
      end
   end
endmodule
